input_port: RTL and testbench

Router input-port encapsulation block. When the arbiter grants it, the block captures one 1024-bit payload with its destination address and packet header. It builds a 17-flit packet of 64-bit words: one header flit followed by 16 payload flits. It stores the flits in an internal 32-entry FIFO and exposes that FIFO to the downstream switch/link through a read-enable/empty interface.

---
 rtl/input_port.sv | 133 +++++++++++++
 tb/tb_input_port.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/input_port.sv
// Router input-port encapsulation: builds a 17-flit packet (header + 16 payload flits) into a 32x64 FIFO.
// Optional macro INPUT_PORT_HDR_PARITY_EN puts even parity of header bits [63:1] into header bit [0].
module input_port (
  input  logic          clk_0,
  input  logic          rst_n_0,
  input  logic          arbiter_gnt_0,
  input  logic [1023:0] data_arbiter_send_0,
  input  logic [9:0]    dst_addr_arbiter_send_0,
  input  logic [8:0]    header_pkt_send_0,
  input  logic          rd_en_0,
  output logic [63:0]   dout_0,
  output logic          empty_0,
  output logic          ready_encap_dfx_0
);

  localparam int unsigned FLIT_W    = 64;
  localparam int unsigned DATA_W    = 1024;
  localparam int unsigned ADDR_W    = 10;
  localparam int unsigned HDR_W     = 9;
  localparam int unsigned DEPTH     = 32;
  localparam int unsigned PTR_W     = 5;
  localparam int unsigned CNT_W     = 6;
  localparam int unsigned NPAY      = 16;
  localparam int unsigned PAY_IDX_W = 4;
  localparam int unsigned PKT_FLITS = 17;
  localparam int unsigned FCNT_W    = 5;

  typedef enum logic [1:0] {IDLE, HEAD, PAY, DONE} state_t;

  state_t               state, state_nxt;
  logic [DATA_W-1:0]    data_q;
  logic [ADDR_W-1:0]    addr_q;
  logic [HDR_W-1:0]     hdr_q;
  logic [PAY_IDX_W-1:0] pay_idx;
  logic [FLIT_W-1:0]    mem [DEPTH];
  logic [PTR_W-1:0]     wr_ptr, rd_ptr;
  logic [CNT_W-1:0]     count, count_nxt;
  logic                 accept, wr_en, rd_fire, hdr_par;
  logic [FLIT_W-1:0]    hdr_flit, wr_data;

  // Grant is only honoured when a whole packet is guaranteed to fit
  assign accept  = (state == IDLE) && arbiter_gnt_0 && (count <= CNT_W'(DEPTH - PKT_FLITS));
  assign rd_fire = rd_en_0 && (count != '0);

`ifdef INPUT_PORT_HDR_PARITY_EN
  assign hdr_par = ^{hdr_q, addr_q, FCNT_W'(PKT_FLITS)};
`else
  assign hdr_par = 1'b0;
`endif

  assign hdr_flit = {hdr_q, addr_q, FCNT_W'(PKT_FLITS),
                     (FLIT_W - HDR_W - ADDR_W - FCNT_W - 1)'(0), hdr_par};

  // Next-state and FIFO write control
  always_comb begin
    state_nxt = state;
    wr_en     = 1'b0;
    wr_data   = hdr_flit;
    case (state)
      IDLE: if (accept) state_nxt = HEAD;
      HEAD: begin
        wr_en     = 1'b1;
        state_nxt = PAY;
      end
      PAY: begin
        wr_en   = 1'b1;
        wr_data = data_q[DATA_W-1 -: FLIT_W];
        if (pay_idx == PAY_IDX_W'(NPAY - 1)) state_nxt = DONE;
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    count_nxt = count;
    case ({wr_en, rd_fire})
      2'b10:   count_nxt = count + CNT_W'(1);
      2'b01:   count_nxt = count - CNT_W'(1);
      default: count_nxt = count;
    endcase
  end

  always_ff @(posedge clk_0 or negedge rst_n_0) begin
    if (!rst_n_0) state <= IDLE;
    else          state <= state_nxt;
  end

  // Capture registers; payload is shifted out MSB-first one flit per cycle
  always_ff @(posedge clk_0 or negedge rst_n_0) begin
    if (!rst_n_0) begin
      data_q  <= '0;
      addr_q  <= '0;
      hdr_q   <= '0;
      pay_idx <= '0;
    end else begin
      if (accept) begin
        data_q  <= data_arbiter_send_0;
        addr_q  <= dst_addr_arbiter_send_0;
        hdr_q   <= header_pkt_send_0;
        pay_idx <= '0;
      end else if (state == PAY) begin
        data_q  <= {data_q[DATA_W-FLIT_W-1:0], FLIT_W'(0)};
        pay_idx <= pay_idx + PAY_IDX_W'(1);
      end
    end
  end

  always_ff @(posedge clk_0) begin
    if (wr_en) mem[wr_ptr] <= wr_data;
  end

  always_ff @(posedge clk_0 or negedge rst_n_0) begin
    if (!rst_n_0) begin
      wr_ptr            <= '0;
      rd_ptr            <= '0;
      count             <= '0;
      dout_0            <= '0;
      empty_0           <= 1'b1;
      ready_encap_dfx_0 <= 1'b0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + PTR_W'(1);
      if (rd_fire) begin
        dout_0 <= mem[rd_ptr];
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
      count             <= count_nxt;
      empty_0           <= (count_nxt == '0);
      ready_encap_dfx_0 <= (state_nxt == DONE);
    end
  end

endmodule

// File: tb/tb_input_port.sv
// Directed self-checking bench for input_port: reset, packet build, drain, busy grant, full guard, mid-packet reset.
module tb_input_port;

  logic          clk_0 = 1'b0;
  logic          rst_n_0;
  logic          arbiter_gnt_0;
  logic [1023:0] data_arbiter_send_0;
  logic [9:0]    dst_addr_arbiter_send_0;
  logic [8:0]    header_pkt_send_0;
  logic          rd_en_0;
  logic [63:0]   dout_0;
  logic          empty_0;
  logic          ready_encap_dfx_0;

  int total = 0;
  int bad   = 0;

  localparam logic [143:0] PAT = 144'h111122223333444455556666777788889999;

  input_port dut (
    .clk_0                   (clk_0),
    .rst_n_0                 (rst_n_0),
    .arbiter_gnt_0           (arbiter_gnt_0),
    .data_arbiter_send_0     (data_arbiter_send_0),
    .dst_addr_arbiter_send_0 (dst_addr_arbiter_send_0),
    .header_pkt_send_0       (header_pkt_send_0),
    .rd_en_0                 (rd_en_0),
    .dout_0                  (dout_0),
    .empty_0                 (empty_0),
    .ready_encap_dfx_0       (ready_encap_dfx_0)
  );

  always #10 clk_0 = ~clk_0;

  task automatic tick();
    @(posedge clk_0);
    #1;
  endtask

  function automatic logic [63:0] exp_flit(input logic [8:0] h, input logic [9:0] a,
                                           input logic [1023:0] d, input int k);
    logic [63:0]   f;
    logic [1023:0] t;
    if (k == 0) begin
      f = {h, a, 5'd17, 40'd0};
`ifdef INPUT_PORT_HDR_PARITY_EN
      f[0] = ^f[63:1];
`endif
    end else begin
      t = d << (64 * (k - 1));
      f = t[1023:960];
    end
    return f;
  endfunction

  task automatic read_flit(output logic [63:0] d);
    rd_en_0 = 1'b1;
    tick();
    rd_en_0 = 1'b0;
    d = dout_0;
  endtask

  // One-cycle grant, then watch ncyc cycles for the ready pulse
  task automatic grant_watch(input logic [8:0] h, input logic [9:0] a, input logic [1023:0] d,
                             input int ncyc, output int pulses, output int first);
    header_pkt_send_0       = h;
    dst_addr_arbiter_send_0 = a;
    data_arbiter_send_0     = d;
    arbiter_gnt_0           = 1'b1;
    tick();
    arbiter_gnt_0 = 1'b0;
    pulses = 0;
    first  = -1;
    for (int i = 1; i <= ncyc; i++) begin
      tick();
      if (ready_encap_dfx_0) begin
        pulses++;
        if (first < 0) first = i;
      end
    end
  endtask

  task automatic test_reset();
    rst_n_0 = 1'b0;
    arbiter_gnt_0 = 1'b0;
    rd_en_0 = 1'b0;
    data_arbiter_send_0 = '0;
    dst_addr_arbiter_send_0 = '0;
    header_pkt_send_0 = '0;
    tick();
    total++; if (empty_0 !== 1'b1) begin bad++; $display("FAIL reset_empty got=%b exp=1", empty_0); end
    total++; if (dout_0 !== 64'h0) begin bad++; $display("FAIL reset_dout got=%h exp=0", dout_0); end
    total++; if (ready_encap_dfx_0 !== 1'b0) begin bad++; $display("FAIL reset_ready got=%b exp=0", ready_encap_dfx_0); end
    rst_n_0 = 1'b1;
    tick();
    total++; if (empty_0 !== 1'b1) begin bad++; $display("FAIL post_reset_empty got=%b exp=1", empty_0); end
  endtask

  task automatic test_single();
    logic [63:0] d;
    int pulses, first;
    header_pkt_send_0       = 9'b100111101;
    dst_addr_arbiter_send_0 = 10'hA;
    data_arbiter_send_0     = {160'h0, {6{PAT}}};
    arbiter_gnt_0 = 1'b1;
    tick();
    arbiter_gnt_0 = 1'b0;
    total++; if (empty_0 !== 1'b1) begin bad++; $display("FAIL single_empty_T got=%b exp=1", empty_0); end
    pulses = 0;
    first  = -1;
    for (int i = 1; i <= 18; i++) begin
      tick();
      if (i == 1) begin
        total++; if (empty_0 !== 1'b0) begin bad++; $display("FAIL single_empty_T1 got=%b exp=0", empty_0); end
      end
      if (ready_encap_dfx_0) begin
        pulses++;
        if (first < 0) first = i;
      end
    end
    total++; if (pulses !== 1) begin bad++; $display("FAIL single_pulses got=%0d exp=1", pulses); end
    total++; if (first !== 17) begin bad++; $display("FAIL single_pulse_cycle got=%0d exp=17", first); end
    read_flit(d);
    total++; if (d !== 64'h9E81510000000000) begin bad++; $display("FAIL single_header got=%h exp=9e81510000000000", d); end
    read_flit(d);
    total++; if (d !== 64'h0) begin bad++; $display("FAIL single_pay0 got=%h exp=0", d); end
  endtask

  task automatic test_drain();
    logic [63:0] d;
    logic [1023:0] data;
    data = {160'h0, {6{PAT}}};
    for (int k = 2; k <= 16; k++) begin
      read_flit(d);
      total++;
      if (d !== exp_flit(9'b100111101, 10'hA, data, k)) begin
        bad++; $display("FAIL drain_flit%0d got=%h exp=%h", k, d, exp_flit(9'b100111101, 10'hA, data, k));
      end
    end
    total++; if (d !== 64'h6666777788889999) begin bad++; $display("FAIL drain_last got=%h exp=6666777788889999", d); end
    total++; if (empty_0 !== 1'b1) begin bad++; $display("FAIL drain_empty got=%b exp=1", empty_0); end
    read_flit(d);
    total++; if (d !== 64'h6666777788889999) begin bad++; $display("FAIL drain_extra_read got=%h exp=6666777788889999", d); end
  endtask

  task automatic test_busy_grant();
    logic [63:0] d;
    logic [1023:0] data;
    int pulses;
    data = {64{16'hA5C3}} ^ {32{32'h0F0F_1234}};
    header_pkt_send_0       = 9'h0AB;
    dst_addr_arbiter_send_0 = 10'h3C5;
    data_arbiter_send_0     = data;
    arbiter_gnt_0 = 1'b1;
    tick();
    arbiter_gnt_0 = 1'b0;
    pulses = 0;
    for (int i = 1; i <= 24; i++) begin
      if (i == 5) begin
        arbiter_gnt_0           = 1'b1;
        header_pkt_send_0       = 9'h1FF;
        dst_addr_arbiter_send_0 = 10'h001;
        data_arbiter_send_0     = '1;
      end
      tick();
      arbiter_gnt_0 = 1'b0;
      if (ready_encap_dfx_0) pulses++;
    end
    total++; if (pulses !== 1) begin bad++; $display("FAIL busy_pulses got=%0d exp=1", pulses); end
    for (int k = 0; k <= 16; k++) begin
      read_flit(d);
      total++;
      if (d !== exp_flit(9'h0AB, 10'h3C5, data, k)) begin
        bad++; $display("FAIL busy_flit%0d got=%h exp=%h", k, d, exp_flit(9'h0AB, 10'h3C5, data, k));
      end
    end
    total++; if (empty_0 !== 1'b1) begin bad++; $display("FAIL busy_empty got=%b exp=1", empty_0); end
  endtask

  task automatic test_full_guard();
    logic [63:0] d;
    logic [1023:0] da, db;
    int pulses, first;
    da = {16{64'h0123_4567_89AB_CDEF}} + 1024'd77;
    db = ~da;
    grant_watch(9'h055, 10'h2AA, da, 20, pulses, first);
    total++; if (pulses !== 1) begin bad++; $display("FAIL full_a_pulses got=%0d exp=1", pulses); end
    grant_watch(9'h1AA, 10'h155, db, 20, pulses, first);
    total++; if (pulses !== 0) begin bad++; $display("FAIL full_cnt17_pulses got=%0d exp=0", pulses); end
    read_flit(d);
    total++; if (d !== exp_flit(9'h055, 10'h2AA, da, 0)) begin bad++; $display("FAIL full_a_hdr got=%h exp=%h", d, exp_flit(9'h055, 10'h2AA, da, 0)); end
    grant_watch(9'h1AA, 10'h155, db, 20, pulses, first);
    total++; if (pulses !== 0) begin bad++; $display("FAIL full_cnt16_pulses got=%0d exp=0", pulses); end
    read_flit(d);
    total++; if (d !== exp_flit(9'h055, 10'h2AA, da, 1)) begin bad++; $display("FAIL full_a_pay0 got=%h exp=%h", d, exp_flit(9'h055, 10'h2AA, da, 1)); end
    grant_watch(9'h1AA, 10'h155, db, 20, pulses, first);
    total++; if (pulses !== 1 || first !== 17) begin bad++; $display("FAIL full_cnt15_accept got=%0d@%0d exp=1@17", pulses, first); end
    for (int k = 2; k <= 16; k++) begin
      read_flit(d);
      total++;
      if (d !== exp_flit(9'h055, 10'h2AA, da, k)) begin
        bad++; $display("FAIL full_a_flit%0d got=%h exp=%h", k, d, exp_flit(9'h055, 10'h2AA, da, k));
      end
    end
    for (int k = 0; k <= 16; k++) begin
      read_flit(d);
      total++;
      if (d !== exp_flit(9'h1AA, 10'h155, db, k)) begin
        bad++; $display("FAIL full_b_flit%0d got=%h exp=%h", k, d, exp_flit(9'h1AA, 10'h155, db, k));
      end
    end
    total++; if (empty_0 !== 1'b1) begin bad++; $display("FAIL full_empty got=%b exp=1", empty_0); end
  endtask

  task automatic test_reset_mid();
    logic [63:0] d;
    logic [1023:0] dc, dd;
    int pulses, first;
    dc = {8{128'hDEAD_BEEF_CAFE_F00D_0000_1111_2222_3333}};
    dd = {32{32'h8765_4321}};
    grant_watch(9'h111, 10'h222, dc, 8, pulses, first);
    total++; if (empty_0 !== 1'b0) begin bad++; $display("FAIL mid_pre_empty got=%b exp=0", empty_0); end
    rst_n_0 = 1'b0;
    #1;
    total++; if (empty_0 !== 1'b1) begin bad++; $display("FAIL mid_reset_empty got=%b exp=1", empty_0); end
    tick();
    rst_n_0 = 1'b1;
    pulses = 0;
    for (int i = 0; i < 25; i++) begin
      tick();
      if (ready_encap_dfx_0) pulses++;
    end
    total++; if (pulses !== 0) begin bad++; $display("FAIL mid_no_pulse got=%0d exp=0", pulses); end
    total++; if (empty_0 !== 1'b1 || dout_0 !== 64'h0) begin bad++; $display("FAIL mid_after_state got=%b/%h exp=1/0", empty_0, dout_0); end
    grant_watch(9'h0F0, 10'h00F, dd, 20, pulses, first);
    total++; if (pulses !== 1 || first !== 17) begin bad++; $display("FAIL mid_new_pkt got=%0d@%0d exp=1@17", pulses, first); end
    for (int k = 0; k <= 16; k++) begin
      read_flit(d);
      total++;
      if (d !== exp_flit(9'h0F0, 10'h00F, dd, k)) begin
        bad++; $display("FAIL mid_flit%0d got=%h exp=%h", k, d, exp_flit(9'h0F0, 10'h00F, dd, k));
      end
    end
    total++; if (empty_0 !== 1'b1) begin bad++; $display("FAIL mid_empty got=%b exp=1", empty_0); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_drain();
    test_busy_grant();
    test_full_guard();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
